// File: rtl/bus_controller.sv
// Bus controller: bridges single CPU requests to a synchronous RAM region
// and one GPIO output register, with lane steering, sign/zero extension
// and misalignment/illegal-size error reporting.
module bus_controller #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] GPIO_ADDR = 32'h0001_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [31:0]                  i_bus_address,
  input  logic [31:0]                  i_bus_data,
  input  logic                         i_bus_DV,
  input  logic [2:0]                   i_bhw,
  input  logic                         i_write_notread,
  output logic [31:0]                  o_bus_data,
  output logic                         o_bus_DV,
  output logic                         o_err,
  output logic [$clog2(RAM_WORDS)-1:0] o_mem_addr,
  output logic [31:0]                  o_mem_wdata,
  output logic [3:0]                   o_mem_be,
  output logic                         o_mem_we,
  output logic                         o_mem_re,
  input  logic [31:0]                  i_mem_rdata,
  output logic [31:0]                  o_gpio
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;

  // Store data replicated across every byte lane for the access size
  function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Byte enables for the addressed lane(s)
  function automatic logic [3:0] lane_be(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Lane select plus sign or zero extension of load data
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] a,
                                              input logic [2:0] bhw);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    b8  = $signed(w[{a, 3'b000} +: 8]);
    h16 = $signed(w[{a[1], 4'b0000} +: 16]);
    case (bhw)
      3'b000:  return 32'(b8);
      3'b001:  return 32'(h16);
      3'b100:  return {24'b0, b8};
      3'b101:  return {16'b0, h16};
      3'b010:  return w;
      default: return '0;
    endcase
  endfunction

  logic        err_in, ram_in, gpio_in, misalign_in, bhw_ok_in;
  logic [1:0]  lane_p0;
  logic [2:0]  bhw_p0;
  logic        wr_p0, err_p0, ram_p0, gpio_p0;
  logic [31:0] data_p0;
  logic [31:0] rdata_p1;
  logic [31:0] resp_data;
  logic        gpio_wr;

  // Decode of the incoming request, used on the accepting edge
  always_comb begin
    bhw_ok_in   = i_bhw inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign_in = 1'b0;
    case (i_bhw[1:0])
      2'b01:   misalign_in = i_bus_address[0];
      2'b10:   misalign_in = |i_bus_address[1:0];
      default: misalign_in = 1'b0;
    endcase
    err_in  = !bhw_ok_in || misalign_in;
    ram_in  = {1'b0, i_bus_address} < RAM_BYTES;
    gpio_in = !ram_in && (i_bus_address == GPIO_ADDR);
  end

  // Request capture on accept and read data capture in WAIT; data needs no reset
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_bus_DV) begin
      lane_p0 <= i_bus_address[1:0];
      bhw_p0  <= i_bhw;
      wr_p0   <= i_write_notread;
      data_p0 <= i_bus_data;
      err_p0  <= err_in;
      ram_p0  <= ram_in;
      gpio_p0 <= gpio_in;
    end
    if (state == WAIT) begin
      rdata_p1 <= i_mem_rdata;
    end
  end

  // Response value and GPIO write qualification
  always_comb begin
    gpio_wr   = gpio_p0 && wr_p0 && !err_p0 && (bhw_p0 == 3'b010);
    resp_data = '0;
    if (!err_p0 && !wr_p0) begin
      if (ram_p0)                           resp_data = load_extend(rdata_p1, lane_p0, bhw_p0);
      else if (gpio_p0 && bhw_p0 == 3'b010) resp_data = o_gpio;
    end
  end

  // Request FSM with registered bus, RAM and GPIO outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_bus_DV    <= 1'b0;
      o_err       <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_bus_data  <= '0;
      o_gpio      <= '0;
    end else begin
      o_bus_DV <= 1'b0;
      o_err    <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (i_bus_DV) begin
            state       <= ACCESS;
            o_mem_addr  <= i_bus_address[AW+1:2];
            o_mem_wdata <= lane_wdata(i_bus_data, i_bhw[1:0]);
            o_mem_be    <= lane_be(i_bus_address[1:0], i_bhw[1:0]);
            o_mem_we    <= ram_in && !err_in && i_write_notread;
            o_mem_re    <= ram_in && !err_in && !i_write_notread;
          end
        end
        ACCESS: begin
          if (gpio_wr) o_gpio <= data_p0;
          state <= (ram_p0 && !err_p0 && !wr_p0) ? WAIT : RESP;
        end
        WAIT: begin
          state <= RESP;
        end
        RESP: begin
          o_bus_DV   <= 1'b1;
          o_err      <= err_p0;
          o_bus_data <= resp_data;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Testbench for bus_controller: directed cases from the requirements plus
// randomized traffic checked against a byte-level reference model.
module tb_bus_controller;

  localparam int unsigned RAM_WORDS = 256;
  localparam int          RAM_BYTES = RAM_WORDS * 4;
  localparam logic [31:0] GPIO_ADDR = 32'h0001_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_bus_address = '0;
  logic [31:0] i_bus_data = '0;
  logic        i_bus_DV = 1'b0;
  logic [2:0]  i_bhw = '0;
  logic        i_write_notread = 1'b0;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;
  logic        o_err;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [31:0] i_mem_rdata = '0;
  logic [31:0] o_gpio;

  bus_controller #(.RAM_WORDS(RAM_WORDS), .GPIO_ADDR(GPIO_ADDR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bus_address(i_bus_address),
    .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV), .i_bhw(i_bhw),
    .i_write_notread(i_write_notread), .o_bus_data(o_bus_data),
    .o_bus_DV(o_bus_DV), .o_err(o_err), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .o_mem_we(o_mem_we),
    .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata), .o_gpio(o_gpio)
  );

  always #5 i_clk = ~i_clk;

  // Word-wide synchronous RAM attached to the DUT
  logic [31:0] ram_w [RAM_WORDS] = '{default: '0};
  always @(posedge i_clk) begin
    if (o_mem_we)
      for (int i = 0; i < 4; i++)
        if (o_mem_be[i]) ram_w[o_mem_addr][8*i +: 8] <= o_mem_wdata[8*i +: 8];
    if (o_mem_re) i_mem_rdata <= ram_w[o_mem_addr];
  end

  // Reference model state: byte-addressed memory and GPIO value
  byte unsigned ref_bytes [RAM_BYTES] = '{default: 8'h00};
  logic [31:0]  ref_gpio = '0;

  int n_cmp = 0;
  int n_fail = 0;

  logic        last_we, last_re, last_err;
  logic [3:0]  last_be;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata, last_rdata;
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] bhw,
                            input logic wr, output logic [31:0] exp_d, output logic exp_err,
                            output int exp_lat, output logic exp_we, output logic exp_re);
    int     size;
    bit     sgn;
    longint v;
    exp_d = '0; exp_err = 1'b0; exp_lat = 2; exp_we = 1'b0; exp_re = 1'b0;
    sgn = 1'b0;
    case (bhw)
      3'b000:  begin size = 1; sgn = 1'b1; end
      3'b001:  begin size = 2; sgn = 1'b1; end
      3'b010:  size = 4;
      3'b100:  size = 1;
      3'b101:  size = 2;
      default: size = 0;
    endcase
    if (size == 0 || (a % size) != 0) begin
      exp_err = 1'b1;
      return;
    end
    if (a < RAM_BYTES) begin
      if (wr) begin
        exp_we = 1'b1;
        for (int i = 0; i < size; i++) ref_bytes[a + i] = d[8*i +: 8];
      end else begin
        exp_re = 1'b1;
        exp_lat = 3;
        v = 0;
        for (int i = 0; i < size; i++) v += longint'(ref_bytes[a + i]) << (8 * i);
        if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        exp_d = v[31:0];
      end
    end else if (a == GPIO_ADDR && size == 4) begin
      if (wr) ref_gpio = d;
      else    exp_d = ref_gpio;
    end
  endtask

  // Issue one request; called with time at 1 unit after a rising edge
  task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] bhw,
                        input logic wr);
    i_bus_address = a; i_bus_data = d; i_bhw = bhw; i_write_notread = wr; i_bus_DV = 1'b1;
    @(posedge i_clk); #1;
    i_bus_DV = 1'b0;
    last_we = o_mem_we; last_re = o_mem_re; last_be = o_mem_be;
    last_wdata = o_mem_wdata; last_addr = o_mem_addr;
    last_lat = 0; last_rdata = '0; last_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge i_clk); #1;
      if (o_bus_DV) begin
        last_lat = k; last_rdata = o_bus_data; last_err = o_err;
        break;
      end
    end
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] bhw, input logic wr);
    logic [31:0] ed;
    logic        ee, ewe, ere;
    int          el;
    ref_access(a, d, bhw, wr, ed, ee, el, ewe, ere);
    bus_op(a, d, bhw, wr);
    check({tag, " latency"}, last_lat, el);
    check({tag, " err"}, last_err, ee);
    check({tag, " we"}, last_we, ewe);
    check({tag, " re"}, last_re, ere);
    if (!wr) check({tag, " data"}, last_rdata, ed);
    if (ewe || ere) check({tag, " addr"}, last_addr, a[9:2]);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " bus_DV"}, o_bus_DV, 0);
    check({tag, " err"}, o_err, 0);
    check({tag, " we"}, o_mem_we, 0);
    check({tag, " re"}, o_mem_re, 0);
    check({tag, " be"}, o_mem_be, 0);
    check({tag, " addr"}, o_mem_addr, 0);
    check({tag, " wdata"}, o_mem_wdata, 0);
    check({tag, " bus_data"}, o_bus_data, 0);
    check({tag, " gpio"}, o_gpio, 0);
  endtask

  logic [31:0] held;
  logic [31:0] ra, rd;
  logic [2:0]  rb;
  logic        rw;
  int          dv_count, gap;
  logic [2:0]  bhw_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outs("reset");
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Word store then load
    op("SW 0x10", 32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
    check("SW 0x10 be", last_be, 4'b1111);
    op("LW 0x10", 32'h10, 32'h0, 3'b010, 1'b0);
    check("LW 0x10 value", last_rdata, 32'hDEADBEEF);
    check("LW 0x10 lat3", last_lat, 3);

    // Sub-word loads with extension
    op("LB 0x13", 32'h13, 32'h0, 3'b000, 1'b0);
    check("LB 0x13 value", last_rdata, 32'hFFFFFFDE);
    op("LBU 0x13", 32'h13, 32'h0, 3'b100, 1'b0);
    check("LBU 0x13 value", last_rdata, 32'h000000DE);
    op("LH 0x12", 32'h12, 32'h0, 3'b001, 1'b0);
    check("LH 0x12 value", last_rdata, 32'hFFFFDEAD);
    op("LHU 0x10", 32'h10, 32'h0, 3'b101, 1'b0);
    check("LHU 0x10 value", last_rdata, 32'h0000BEEF);

    // Byte store lane steering
    op("SB 0x11", 32'h11, 32'h0000005A, 3'b000, 1'b1);
    check("SB 0x11 be", last_be, 4'b0010);
    check("SB 0x11 wdata", last_wdata, 32'h5A5A5A5A);
    op("LW 0x10 after SB", 32'h10, 32'h0, 3'b010, 1'b0);
    check("LW after SB value", last_rdata, 32'hDEAD5AEF);

    // Misalignment and illegal size
    op("LW 0x02", 32'h02, 32'h0, 3'b010, 1'b0);
    check("LW 0x02 err", last_err, 1);
    op("SH 0x01", 32'h01, 32'h1234, 3'b001, 1'b1);
    check("SH 0x01 err", last_err, 1);
    op("LW illegal bhw", 32'h10, 32'h0, 3'b011, 1'b0);
    check("illegal bhw err", last_err, 1);
    op("LW 0x10 after errs", 32'h10, 32'h0, 3'b010, 1'b0);

    // GPIO and unmapped
    op("SW GPIO", GPIO_ADDR, 32'h000000A5, 3'b010, 1'b1);
    check("gpio after SW", o_gpio, 32'hA5);
    op("LW GPIO", GPIO_ADDR, 32'h0, 3'b010, 1'b0);
    check("LW GPIO value", last_rdata, 32'hA5);
    op("SB GPIO", GPIO_ADDR, 32'h000000FF, 3'b000, 1'b1);
    check("gpio after SB", o_gpio, 32'hA5);
    op("LB GPIO", GPIO_ADDR, 32'h0, 3'b000, 1'b0);
    op("LW unmapped", 32'h0002_0000, 32'h0, 3'b010, 1'b0);
    check("LW unmapped err", last_err, 0);

    // Response data holds and DV is a single pulse
    held = o_bus_data;
    repeat (3) @(posedge i_clk);
    #1;
    check("bus_data hold", o_bus_data, held);
    check("bus_DV single pulse", o_bus_DV, 0);

    // Reset while waiting for RAM read data
    i_bus_address = 32'h10; i_bhw = 3'b010; i_write_notread = 1'b0; i_bus_DV = 1'b1;
    @(posedge i_clk); #1; i_bus_DV = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    check_reset_outs("reset in WAIT");
    ref_gpio = '0;
    @(negedge i_clk); i_rst_n = 1'b1;
    dv_count = 0;
    repeat (5) begin
      @(posedge i_clk); #1;
      if (o_bus_DV) dv_count++;
    end
    check("no response after abort", dv_count, 0);
    op("LW after reset", 32'h10, 32'h0, 3'b010, 1'b0);
    check("LW after reset lat3", last_lat, 3);

    // Reset during the ACCESS cycle of a store suppresses it
    i_bus_address = 32'h40; i_bus_data = 32'h12345678; i_bhw = 3'b010;
    i_write_notread = 1'b1; i_bus_DV = 1'b1;
    @(posedge i_clk); #1; i_bus_DV = 1'b0;
    check("store we in ACCESS", o_mem_we, 1);
    i_rst_n = 1'b0;
    #1;
    check("store we dropped by reset", o_mem_we, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    op("LW 0x40 after aborted SW", 32'h40, 32'h0, 3'b010, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        7:       ra = GPIO_ADDR + 32'($urandom_range(0, 3));
        8:       ra = 32'h0000_0400 + 32'($urandom_range(0, 32'h0000_F000));
        9:       ra = 32'h0002_0000 + 32'($urandom_range(0, 255));
        default: ra = 32'($urandom_range(0, RAM_BYTES - 1));
      endcase
      rd = $urandom;
      rb = bhw_tab[$urandom_range(0, 7)];
      rw = 1'($urandom_range(0, 1));
      op("random", ra, rd, rb, rw);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge i_clk); #1;
      end
    end
    check("final gpio", o_gpio, ref_gpio);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
